mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one unified word memory port between instruction fetch (IF) and load/store (D).
//  Sits between the core front end, the LSU, and the single-port memory.
//  Selects one requester, holds its payload until the memory accepts it, and allows one
//  outstanding transaction. Routes the response back to the owner.
// PARAMETERS
//  ADDR_W        32  address width, byte address
//  DATA_W        32  data width
//  STARVE_LIMIT  4   consecutive D grants allowed while IF waits (only with MEM_ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch request accepted by memory this cycle
//  if_rvalid  out  1       fetch data valid
//  if_rdata   out  DATA_W  fetch data
//  d_req      in   1       data request; held with payload until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_be       in   4       store byte enables
//  d_gnt      out  1       data request accepted this cycle
//  d_rvalid   out  1       load data / store ack valid
//  d_rdata    out  DATA_W  load data
//  mem_req    out  1       request to memory
//  mem_we     out  1       write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_be     out  4       memory byte enables
//  mem_gnt    in   1       memory accepts mem_req this cycle
//  mem_rvalid in   1       memory response; required for every read and write
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Registered state: {IDLE, HOLD, WAIT}, owner (0 = IF, 1 = D), starve_cnt.
//  - Reset (rst = 0 at posedge): state IDLE, owner 0, starve_cnt 0.
//    While rst = 0, every output is forced to 0, including mem_req, gnt, rvalid and busy.
//    A transaction in flight is abandoned. A later mem_rvalid arriving in IDLE is ignored.
//  - IDLE:
//    - pick = D if d_req, else IF if if_req.
//    - mem_req = pick valid; mem_* payload driven combinationally from the picked requester.
//    - If mem_gnt: pick's gnt = 1, owner <= pick, go to WAIT. Else go to HOLD with owner <= pick.
//  - HOLD: mem_req = 1 with the owner's payload; arbitration is frozen, so no switching.
//    On mem_gnt, the owner's gnt = 1 and the block goes to WAIT.
//  - WAIT: mem_req = 0. On mem_rvalid, the owner's rvalid = 1 and the block goes to IDLE.
//    The next arbitration happens in the following cycle.
//  - if_rdata = d_rdata = mem_rdata, always. Only the rvalid strobes qualify the data.
//  - IF payload to memory: mem_we = 0, mem_be = 4'hF, mem_wdata = 0.
//  - Minimum latency:
//    - gnt happens in the req cycle when mem_gnt = 1 there.
//    - rvalid comes at the earliest 1 cycle after gnt.
//    - Back-to-back transactions are separated by at least 1 IDLE cycle.
//  - mem_rvalid outside WAIT is ignored. mem_gnt outside IDLE/HOLD is ignored.
//  - A requester dropping req before gnt is a protocol violation.
//    The arbiter still completes the held transaction.
//  - gnt and rvalid are never both asserted to the same requester in the same cycle.
//    IF and D are never granted in the same cycle.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined:
//    - starve_cnt increments on each D grant while if_req = 1, saturating at STARVE_LIMIT.
//    - starve_cnt clears on an IF grant or when if_req = 0 in IDLE.
//    - In IDLE, if starve_cnt == STARVE_LIMIT and if_req = 1, IF wins over d_req.
//  Not defined: strict D-over-IF priority; starve_cnt is absent (reads 0).
// TESTING
//  1. Reset: rst = 0 with if_req = d_req = 1 and mem_gnt = 1 -> all outputs 0.
//     On release, if d_req = 1, d_gnt = 1 in the first active cycle.
//  2. Single fetch: if_req, if_addr = 0x10, mem_gnt = 1 -> mem_addr = 0x10 and if_gnt same cycle.
//     mem_rvalid 2 cycles later with rdata 0x3E800093 -> if_rvalid = 1, if_rdata = 0x3E800093.
//  3. Contention: if_req and d_req both set, d_we = 1, d_addr = 8, d_wdata = 0x3FE, d_be = F
//     -> D granted first. After d_rvalid, one IDLE cycle, then if_gnt.
//  4. Hold: d_req with mem_gnt = 0 for 3 cycles, if_req raised in cycle 2
//     -> mem_addr stays d_addr, no IF switch, d_gnt in cycle 4.
//  5. Mid-flight reset: rst = 0 during WAIT, then mem_rvalid after release
//     -> no rvalid to either requester, busy = 0.
//  6. MEM_ARB_STARVE_GUARD_EN with STARVE_LIMIT = 4: d_req and if_req held high
//     -> after 4 D grants the 5th grant goes to IF, then D resumes.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word memory port between fetch (IF) and load/store (D); optional IF starvation guard via MEM_ARB_STARVE_GUARD_EN
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    state_t          state, state_nxt;
    logic            owner;
    logic [CW-1:0]   starve_cnt;
    logic            req_any, starve_win, pick, sel, gnt_ok;
    assign req_any    = d_req | if_req;
    assign starve_win = GUARD && if_req && (starve_cnt == CW'(STARVE_LIMIT));
    assign pick       = d_req && !starve_win;
    assign sel        = (state == IDLE) ? pick : owner;
    assign gnt_ok     = mem_gnt && ((state == IDLE && req_any) || state == HOLD);
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    // owner latches the pick whenever arbitration happens in IDLE
    always_ff @(posedge clk) begin
        if (!rst)                        owner <= 1'b0;
        else if (state == IDLE && req_any) owner <= pick;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    // count D grants that bypass a waiting IF, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst)                                  starve_cnt <= '0;
        else if (d_gnt && if_req)                  starve_cnt <= (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
        else if (if_gnt || (state == IDLE && !if_req)) starve_cnt <= '0;
    end
`else
    assign starve_cnt = '0;
`endif
    // next state: arbitrate in IDLE, hold until accepted, wait for the response
    always_comb begin
        state_nxt = (state == IDLE) ? (req_any ? (mem_gnt ? WAIT : HOLD) : IDLE) :
                    (state == HOLD) ? (mem_gnt ? WAIT : HOLD) :
                    (mem_rvalid ? IDLE : WAIT);
    end
    // outputs: payload from the selected requester, strobes routed to the owner, all zero in reset
    always_comb begin
        mem_req   = rst && ((state == IDLE && req_any) || state == HOLD);
        mem_we    = rst && sel && d_we;
        mem_addr  = !rst ? '0 : sel ? d_addr : if_addr;
        mem_wdata = (rst && sel) ? d_wdata : '0;
        mem_be    = !rst ? 4'h0 : sel ? d_be : 4'hF;
        if_gnt    = rst && gnt_ok && !sel;
        d_gnt     = rst && gnt_ok && sel;
        if_rvalid = rst && state == WAIT && mem_rvalid && !owner;
        d_rvalid  = rst && state == WAIT && mem_rvalid && owner;
        if_rdata  = rst ? mem_rdata : '0;
        d_rdata   = rst ? mem_rdata : '0;
        busy      = rst && state != IDLE;
    end
endmodule
